// File: rtl/midi_rx.sv
// MIDI IN receiver: 8N1 at 16x oversampling with 3-sample majority vote,
// presenting each byte through a one-entry valid/ready buffer.
module midi_rx #(
  parameter int SAMPLE_DIV = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun
);
  localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      phase_q, phase_d;
  logic [3:0]      bit_q, bit_d;
  logic [1:0]      smp_q, smp_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;

  logic            rxs, tick, vote, vote_tick, bit_end, done;
  logic [3:0]      phase_nx;

  always_comb begin
    sync_d    = {sync_q[0], rxd};
    rxs       = sync_q[1];
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    smp_d     = smp_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    done      = 1'b0;
    tick      = (cnt_q == CW'(SAMPLE_DIV - 1));
    // phase_nx is the number of ticks elapsed in the bit once this tick lands,
    // so samples fall at 7/8/9 ticks past the bit start, centred on the bit.
    phase_nx  = phase_q + 4'd1;
    vote      = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    vote_tick = tick && (phase_nx == 4'd9);
    bit_end   = tick && (phase_q == 4'd15);

    if (state_q == IDLE || state_q == BRK) begin
      cnt_d = '0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick) begin
        phase_d = phase_nx;
        if (phase_nx == 4'd7) smp_d[0] = rxs;
        if (phase_nx == 4'd8) smp_d[1] = rxs;
        if (bit_end) bit_d = bit_q + 4'd1;
      end
    end

    case (state_q)
      IDLE: begin
        phase_d = '0;
        bit_d   = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (vote_tick && vote) state_d = IDLE;
        else if (bit_end)      state_d = DATA;
      end
      DATA: begin
        if (vote_tick) shift_d = {vote, shift_q[7:1]};
        if (bit_end && bit_q == 4'd8) state_d = STOP;
      end
      STOP: begin
        // Decide at the vote rather than the bit end so an early start edge
        // of the next frame is not missed.
        if (vote_tick) begin
          if (vote) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
endmodule
